// File: rtl/fifo_rd_stream_if.sv
// Signal bundle between the synchronous FIFO's read port and the stream consumer.
// The master modport is the adapter's view; slave is the FIFO/consumer side.
interface fifo_rd_stream_if #(
   parameter int WIDTH = 8
);
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_rd_en;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      input  m_ready,
      output fifo_rd_en,
      output m_valid,
      output m_data
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      output m_ready,
      input  fifo_rd_en,
      input  m_valid,
      input  m_data
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side adapter: hides the FIFO's 1-cycle read latency behind a small
// prefetch buffer. Optional transfer counter enabled by FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3,
   parameter int PW    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef FIFO_RD_STREAM_CNT_EN
   output logic [15:0]        xfer_cnt,
`endif
   fifo_rd_stream_if.master   bus
);

   localparam int            OW       = $clog2(DEPTH + 1);
   localparam int            LAST_I   = DEPTH - 1;
   localparam logic [PW-1:0] LAST     = LAST_I[PW-1:0];
   localparam logic [PW-1:0] PTR_ONE  = 1;
   localparam logic [OW-1:0] OCC_ONE  = 1;
   localparam logic [OW:0]   DEPTH_W  = DEPTH[OW:0];

   logic [OW-1:0]    occ;
   logic [OW-1:0]    occ_nxt;
   logic             rd_pend;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [OW:0]      inflight;
   logic             rd_en;
   logic             push;
   logic             pop;
   logic             valid;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PTR_ONE;
   endfunction

   // Reads are issued only when a slot is guaranteed for the word, counting the
   // one already in flight, so the buffer can never overflow.
   always_comb begin
      inflight = {1'b0, occ} + {{OW{1'b0}}, rd_pend};
      rd_en    = rst_n && !bus.fifo_empty && (inflight < DEPTH_W);
      valid    = (occ != '0);
      push     = rd_pend;
      pop      = valid && bus.m_ready;
      occ_nxt  = occ;
      if (push && !pop) begin
         occ_nxt = occ + OCC_ONE;
      end else if (!push && pop) begin
         occ_nxt = occ - OCC_ONE;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = valid;
   assign bus.m_data     = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ     <= '0;
         rd_pend <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         occ     <= occ_nxt;
         rd_pend <= rd_en;
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
      end
   end

   // Buffer storage is deliberately left unreset; a read landing during reset is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem[wr_ptr] <= bus.fifo_data;
      end
   end

`ifdef FIFO_RD_STREAM_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (pop && (xfer_cnt != 16'hFFFF)) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO and stream model, per-cycle compare,
// directed scenarios plus random traffic; counter scenario with FIFO_RD_STREAM_CNT_EN.
module tb_fifo_rd_stream;

   localparam int WIDTH    = 8;
   localparam int DEPTH    = 3;
   localparam int FIFO_CAP = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fifo_rd_stream_if #(.WIDTH(WIDTH)) bus ();

`ifdef FIFO_RD_STREAM_CNT_EN
   logic [15:0] xfer_cnt;
`endif

   fifo_rd_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef FIFO_RD_STREAM_CNT_EN
      .xfer_cnt (xfer_cnt),
`endif
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] fifo_q  [$];
   logic [7:0] stage_q [$];
   logic [7:0] buf_q   [$];
   logic [7:0] sb_q    [$];
   logic       pend = 1'b0;
   logic [7:0] pend_data = 8'h00;
   int         pop_total = 0;
   int         cnt_model = 0;
   bit         model_live = 1'b0;

   logic       exp_en;
   logic       exp_valid;
   logic [7:0] exp_data;
   logic [7:0] nd;
   logic       have_nd;
   logic       new_empty;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fifoLoad(input logic [7:0] d);
      stage_q.push_back(d);
   endtask

   task automatic applyStimulus(input logic rst_v, input logic rdy_v);
      @(negedge clk);
      rst_n       = rst_v;
      bus.m_ready = rdy_v;
      #2;
   endtask

   // Reference model: the prefetch buffer is a plain queue of words, a read in
   // flight is a pending word, and the FIFO is another queue.
   initial begin
      bus.fifo_empty = 1'b1;
      bus.fifo_data  = 8'h00;
      forever begin
         @(negedge clk);
         #4;
         exp_en    = rst_n && (fifo_q.size() != 0) && ((buf_q.size() + int'(pend)) < DEPTH);
         exp_valid = (buf_q.size() != 0);
         exp_data  = exp_valid ? buf_q[0] : 8'h00;
         if (model_live) begin
            checkOutput("fifo_rd_en", {31'd0, bus.fifo_rd_en}, {31'd0, exp_en});
            checkOutput("m_valid", {31'd0, bus.m_valid}, {31'd0, exp_valid});
            checkOutput("m_data", {24'd0, bus.m_data}, {24'd0, exp_data});
            checkOutput("occ", 32'(dut.occ), 32'(buf_q.size()));
            checkOutput("occ_plus_pend_le_depth",
                        32'((32'(dut.occ) + 32'(dut.rd_pend)) <= DEPTH), 32'd1);
`ifdef FIFO_RD_STREAM_CNT_EN
            checkOutput("xfer_cnt", {16'd0, xfer_cnt}, 32'(cnt_model));
`endif
         end
         have_nd = 1'b0;
         nd      = 8'h00;
         if (!rst_n) begin
            fifo_q.delete();
            buf_q.delete();
            sb_q.delete();
            pend       = 1'b0;
            cnt_model  = 0;
            model_live = 1'b1;
         end else begin
            if (exp_valid && bus.m_ready) begin
               if (sb_q.size() == 0) begin
                  checkOutput("stream_order_underflow", 32'd1, 32'd0);
               end else begin
                  checkOutput("stream_order", {24'd0, bus.m_data}, {24'd0, sb_q.pop_front()});
               end
               void'(buf_q.pop_front());
               pop_total++;
               if (cnt_model < 65535) cnt_model++;
            end
            if (pend) buf_q.push_back(pend_data);
            pend = exp_en;
            if (exp_en) begin
               nd        = fifo_q.pop_front();
               pend_data = nd;
               have_nd   = 1'b1;
            end
         end
         while (stage_q.size() != 0 && fifo_q.size() < FIFO_CAP) begin
            nd = stage_q.pop_front();
            fifo_q.push_back(nd);
            sb_q.push_back(nd);
            if (have_nd) nd = pend_data;
         end
         new_empty = (fifo_q.size() == 0);
         @(posedge clk);
         if (have_nd) bus.fifo_data <= pend_data;
         bus.fifo_empty <= new_empty;
      end
   end

   initial begin
      int rd_run;
      int rd_best;
      int v_run;
      int v_best;
      int v_idx;
      int rd_count;
      int p0;
      int loaded;
      int cyc;

      bus.m_ready = 1'b0;
      applyStimulus(1'b0, 1'b0);

      // Reset holds off reads even with data waiting; release reads at once.
      for (int i = 0; i < 2; i++) begin
         fifoLoad(8'h55 + 8'(i));
         applyStimulus(1'b0, 1'b1);
         checkOutput("reset_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
         checkOutput("reset_m_valid", {31'd0, bus.m_valid}, 32'd0);
      end
      fifoLoad(8'h57);
      applyStimulus(1'b1, 1'b1);
      checkOutput("release_rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
      repeat (6) applyStimulus(1'b1, 1'b1);

      // Single word: read, then data visible two cycles later for one cycle.
      fifoLoad(8'hA5);
      applyStimulus(1'b1, 1'b1);
      checkOutput("single_rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
      checkOutput("single_valid_c0", {31'd0, bus.m_valid}, 32'd0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("single_rd_en_c1", {31'd0, bus.fifo_rd_en}, 32'd0);
      checkOutput("single_valid_c1", {31'd0, bus.m_valid}, 32'd0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("single_valid_c2", {31'd0, bus.m_valid}, 32'd1);
      checkOutput("single_data_c2", {24'd0, bus.m_data}, 32'hA5);
      applyStimulus(1'b1, 1'b1);
      checkOutput("single_valid_c3", {31'd0, bus.m_valid}, 32'd0);
      checkOutput("single_occ_c3", 32'(dut.occ), 32'd0);

      // Streaming 16 words back to back.
      for (int i = 0; i < 16; i++) fifoLoad(8'(i));
      rd_run = 0; rd_best = 0; v_run = 0; v_best = 0; v_idx = 0;
      for (int c = 0; c < 24; c++) begin
         applyStimulus(1'b1, 1'b1);
         rd_run  = bus.fifo_rd_en ? rd_run + 1 : 0;
         rd_best = (rd_run > rd_best) ? rd_run : rd_best;
         v_run   = bus.m_valid ? v_run + 1 : 0;
         v_best  = (v_run > v_best) ? v_run : v_best;
         if (bus.m_valid) begin
            checkOutput("stream_data", {24'd0, bus.m_data}, 32'(v_idx));
            v_idx++;
         end
      end
      checkOutput("stream_rd_en_run", 32'(rd_best), 32'd16);
      checkOutput("stream_valid_run", 32'(v_best), 32'd16);

      // Backpressure: buffer fills to three and reads stop.
      for (int i = 0; i < 8; i++) fifoLoad(8'h10 + 8'(i));
      rd_count = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1, 1'b0);
         rd_count += int'(bus.fifo_rd_en);
      end
      checkOutput("bp_reads", 32'(rd_count), 32'd3);
      checkOutput("bp_occ", 32'(dut.occ), 32'd3);
      checkOutput("bp_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
      checkOutput("bp_valid", {31'd0, bus.m_valid}, 32'd1);
      checkOutput("bp_data", {24'd0, bus.m_data}, 32'h10);
      p0 = pop_total;
      repeat (15) applyStimulus(1'b1, 1'b1);
      checkOutput("bp_delivered", 32'(pop_total - p0), 32'd8);

      // Alternating ready over 40 words; pointers wrap many times.
      p0 = pop_total; loaded = 0; cyc = 0;
      while ((pop_total - p0) < 40 && cyc < 400) begin
         if (loaded < 40 && (fifo_q.size() + stage_q.size()) < FIFO_CAP) begin
            fifoLoad(8'h40 + 8'(loaded));
            loaded++;
         end
         applyStimulus(1'b1, (cyc % 2) == 0);
         cyc++;
      end
      applyStimulus(1'b1, 1'b1);
      checkOutput("alt_delivered", 32'(pop_total - p0), 32'd40);

      // Random traffic with occasional resets.
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 1) == 1 && (fifo_q.size() + stage_q.size()) < FIFO_CAP)
            fifoLoad(8'($urandom));
         applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0));
      end
      repeat (30) applyStimulus(1'b1, 1'b1);
      checkOutput("drain_valid", {31'd0, bus.m_valid}, 32'd0);

`ifdef FIFO_RD_STREAM_CNT_EN
      // Counter saturates after 65535 transfers and clears only on reset.
      p0 = pop_total; cyc = 0;
      while ((pop_total - p0) < 70000 && cyc < 72000) begin
         if ((fifo_q.size() + stage_q.size()) < FIFO_CAP) fifoLoad(8'(cyc));
         applyStimulus(1'b1, 1'b1);
         cyc++;
      end
      repeat (3) applyStimulus(1'b1, 1'b1);
      checkOutput("cnt_saturated", {16'd0, xfer_cnt}, 32'h0000FFFF);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      checkOutput("cnt_reset", {16'd0, xfer_cnt}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
